sysbus_mem: RTL and testbench

On-chip main-memory responder for the SystemBus, the target end of line-fill and write-back traffic issued by the cache users. It holds a 256 KiB block-RAM-backed line store. It accepts one 128-bit line request at a time, services it after a fixed programmable latency, and returns data or an error through a valid/ready response channel. It sits below the bus arbiter and stands in for external DRAM in simulation and FPGA builds.

---
 rtl/sysbus_mem.sv | 196 +++++++++++++++++++
 tb/tb_sysbus_mem.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem.sv
// sysbus_mem: on-chip line-store responder for SystemBus line fills and write-backs.
// Accepts one 128-bit line request at a time. Each request is serviced after a fixed
// LATENCY. The response (read data or an out-of-range error) is returned on a
// valid/ready channel. The backing array is a single-port synchronous RAM.
module sysbus_mem #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          SIZE_BYTES = 262144,
    parameter int          LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    input  logic         req_we,
    input  logic [127:0] req_wdata,
    input  logic [15:0]  req_wmask,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_rdata,
    output logic         resp_error
);

    localparam int          AW          = $clog2(SIZE_BYTES);
    localparam int          IW          = AW - 4;
    localparam int          DEPTH       = SIZE_BYTES / 16;
    localparam logic [32:0] LIMIT       = {1'b0, BASE} + 33'(SIZE_BYTES);
    localparam logic [3:0]  CNT_LOAD    = 4'(LATENCY - 1);
    localparam logic        DIRECT_RESP = (LATENCY == 32'sd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The 33-bit compare keeps BASE+SIZE_BYTES from wrapping at the top of the address space.
    function automatic logic in_range_f(input logic [31:0] addr);
        logic [32:0] addr33;
        addr33 = {1'b0, addr};
        return (addr33 >= {1'b0, BASE}) && (addr33 < LIMIT);
    endfunction

    state_t         state_r;
    logic [3:0]     cnt_r;
    logic [27:0]    addr_r;
    logic           we_r;
    logic [127:0]   wdata_r;
    logic [15:0]    wmask_r;
    logic           in_range_r;
    logic           req_ready_r;
    logic           resp_valid_r;
    logic           resp_error_r;
    logic           rd_ok_r;
    logic [127:0]   ram_q_r;
    logic [127:0]   mem_r [DEPTH];

    logic           accept_s;
    logic           req_in_range_s;
    logic           acc_go_s;
    logic [31:0]    acc_addr_s;
    logic           acc_we_s;
    logic [127:0]   acc_wdata_s;
    logic [15:0]    acc_wmask_s;
    logic           acc_ok_s;
    logic [IW-1:0]  idx_s;

    assign accept_s       = req_valid && req_ready_r && (state_r == IDLE);
    assign req_in_range_s = in_range_f(req_addr);
    assign idx_s          = IW'((acc_addr_s - BASE) >> 4);

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_error = resp_error_r;
    // Only in-range reads expose the RAM output; writes and errors return zero.
    assign resp_rdata = rd_ok_r ? ram_q_r : 128'd0;

    // Select the access operands and decide whether the array access happens this cycle.
    always_comb begin
        acc_go_s    = 1'b0;
        acc_addr_s  = {addr_r, 4'h0};
        acc_we_s    = we_r;
        acc_wdata_s = wdata_r;
        acc_wmask_s = wmask_r;
        acc_ok_s    = in_range_r;
        case (state_r)
            IDLE: begin
                // With a one-cycle latency the access uses the live request directly.
                if (accept_s && DIRECT_RESP) begin
                    acc_go_s    = 1'b1;
                    acc_addr_s  = req_addr;
                    acc_we_s    = req_we;
                    acc_wdata_s = req_wdata;
                    acc_wmask_s = req_wmask;
                    acc_ok_s    = req_in_range_s;
                end else begin
                    acc_go_s = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    acc_go_s = 1'b1;
                end else begin
                    acc_go_s = 1'b0;
                end
            end
            default: begin
                acc_go_s = 1'b0;
            end
        endcase
    end

    // Single-port line store: byte-masked write or registered read. A reset cycle blocks the access.
    always_ff @(posedge clk) begin
        if (acc_go_s && acc_ok_s && !rst) begin
            if (acc_we_s) begin
                for (int i = 0; i < 16; i++) begin
                    if (acc_wmask_s[i]) begin
                        mem_r[idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
                    end
                end
            end else begin
                ram_q_r <= mem_r[idx_s];
            end
        end
    end

    // Request/latency/response sequencing with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            addr_r       <= 28'd0;
            we_r         <= 1'b0;
            wdata_r      <= 128'd0;
            wmask_r      <= 16'd0;
            in_range_r   <= 1'b0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            rd_ok_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    req_ready_r <= 1'b1;
                    if (accept_s) begin
                        addr_r      <= req_addr[31:4];
                        we_r        <= req_we;
                        wdata_r     <= req_wdata;
                        wmask_r     <= req_wmask;
                        in_range_r  <= req_in_range_s;
                        req_ready_r <= 1'b0;
                        if (acc_go_s) begin
                            state_r      <= RESP;
                            cnt_r        <= 4'd0;
                            resp_valid_r <= 1'b1;
                            resp_error_r <= !acc_ok_s;
                            rd_ok_r      <= acc_ok_s && !acc_we_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (acc_go_s) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_error_r <= !acc_ok_s;
                        rd_ok_r      <= acc_ok_s && !acc_we_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_r      <= IDLE;
                        resp_valid_r <= 1'b0;
                        resp_error_r <= 1'b0;
                        rd_ok_r      <= 1'b0;
                        req_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= 4'd0;
                    req_ready_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_error_r <= 1'b0;
                    rd_ok_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_mem.sv
// tb_sysbus_mem: directed scoreboard bench for sysbus_mem.
// Issued requests push their expected response; an independent monitor pops on each handshake.
module tb_sysbus_mem;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = 32'd0;
    logic         req_we = 1'b0;
    logic [127:0] req_wdata = 128'd0;
    logic [15:0]  req_wmask = 16'd0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [127:0] resp_rdata;
    logic         resp_error;

    sysbus_mem #(
        .BASE      (32'h8000_0000),
        .SIZE_BYTES(262144),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_error(resp_error)
    );

    localparam logic [127:0] D_LINE  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D_MASK  = 128'h00112233_44556677_8899AABB_CCDDFFFF;
    localparam logic [127:0] P_LINE  = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] Q_LINE  = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] R_LINE  = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    localparam logic [127:0] ONES    = {128{1'b1}};

    typedef struct {
        logic [127:0] rdata;
        logic         err;
        int           acc;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_item;
    exp_t push_item;
    bit   awaiting = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    // Free-running edge counter used to time acceptance against response.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: verifies response latency once per item, then pops and compares on handshake.
    always @(posedge clk) begin
        if (rst) begin
            awaiting = 1'b1;
        end else if (resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_resp: got resp_valid=1, required no response");
            end else begin
                if (awaiting) begin
                    // Valid rises on the LAT-th edge after acceptance and is first seen before the next.
                    check({sb_q[0].name, "_latency"}, 128'(cyc - sb_q[0].acc), 128'(LAT + 1));
                    awaiting = 1'b0;
                end
                if (resp_ready === 1'b1) begin
                    mon_item = sb_q.pop_front();
                    check({mon_item.name, "_rdata"}, resp_rdata, mon_item.rdata);
                    check({mon_item.name, "_error"}, 128'(resp_error), 128'(mon_item.err));
                    awaiting = 1'b1;
                end
            end
        end
    end

    task automatic issue(input string name, input logic [31:0] a, input logic we,
                         input logic [127:0] wd, input logic [15:0] wm,
                         input logic [127:0] er, input logic ee, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: req_ready=%b, required 1", name, req_ready);
            return;
        end
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        req_wmask = wm;
        @(posedge clk);
        if (push) begin
            push_item.rdata = er;
            push_item.err   = ee;
            push_item.acc   = cyc;
            push_item.name  = name;
            sb_q.push_back(push_item);
        end
        @(negedge clk);
        // Scramble request fields while the DUT is busy; it must ignore them.
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_we    = 1'($urandom);
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        req_wmask = 16'($urandom);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset held for three cycles; outputs must be quiet and req_ready low.
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_valid", 128'(resp_valid), 128'd0);
            check("rst_error", 128'(resp_error), 128'd0);
            check("rst_rdata", resp_rdata, 128'd0);
            check("rst_ready", 128'(req_ready), 128'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 128'(req_ready), 128'd1);

        // Full write then read with the low address bits set.
        issue("w_full",   32'h8000_0010, 1'b1, D_LINE, 16'hFFFF, 128'd0, 1'b0, 1'b1);
        issue("r_full",   32'h8000_001C, 1'b0, 128'd0, 16'h0000, D_LINE, 1'b0, 1'b1);
        // Byte-masked write touches only bytes 0 and 1.
        issue("w_mask",   32'h8000_0010, 1'b1, ONES,   16'h0003, 128'd0, 1'b0, 1'b1);
        issue("r_mask",   32'h8000_0010, 1'b0, 128'd0, 16'hFFFF, D_MASK, 1'b0, 1'b1);
        // Last line in range, and line 0.
        issue("w_last",   32'h8003_FFF0, 1'b1, P_LINE, 16'hFFFF, 128'd0, 1'b0, 1'b1);
        issue("r_last",   32'h8003_FFF0, 1'b0, 128'd0, 16'h0000, P_LINE, 1'b0, 1'b1);
        issue("w_first",  32'h8000_0000, 1'b1, Q_LINE, 16'hFFFF, 128'd0, 1'b0, 1'b1);
        // Out-of-range reads and writes; writes would alias line 0 / last line if wrapped.
        issue("r_above",  32'h8004_0000, 1'b0, 128'd0, 16'h0000, 128'd0, 1'b1, 1'b1);
        issue("r_below",  32'h7FFF_FFF0, 1'b0, 128'd0, 16'h0000, 128'd0, 1'b1, 1'b1);
        issue("r_top",    32'hFFFF_FFF0, 1'b0, 128'd0, 16'h0000, 128'd0, 1'b1, 1'b1);
        issue("w_above",  32'h8004_0000, 1'b1, ONES,   16'hFFFF, 128'd0, 1'b1, 1'b1);
        issue("w_below",  32'h7FFF_FFF0, 1'b1, ONES,   16'hFFFF, 128'd0, 1'b1, 1'b1);
        issue("r_first2", 32'h8000_0000, 1'b0, 128'd0, 16'h0000, Q_LINE, 1'b0, 1'b1);
        issue("r_last2",  32'h8003_FFF0, 1'b0, 128'd0, 16'h0000, P_LINE, 1'b0, 1'b1);
        drain("main");

        // Backpressure: response must hold for 10 cycles and ignore a stray request.
        resp_ready = 1'b0;
        issue("bp_read", 32'h8000_0010, 1'b0, 128'd0, 16'h0000, D_MASK, 1'b0, 1'b1);
        n = 0;
        while (resp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_arrives", 128'(resp_valid), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 128'(resp_valid), 128'd1);
            check("bp_rdata", resp_rdata, D_MASK);
            check("bp_ready", 128'(req_ready), 128'd0);
            if (i == 3) begin
                req_valid = 1'b1;
                req_addr  = 32'h8000_0010;
                req_we    = 1'b1;
                req_wdata = 128'd0;
                req_wmask = 16'hFFFF;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after", 128'(req_ready), 128'd1);
        issue("r_after_bp", 32'h8000_0010, 1'b0, 128'd0, 16'h0000, D_MASK, 1'b0, 1'b1);
        drain("bp");

        // Reset two cycles after accepting a write aborts it.
        issue("w_pre", 32'h8000_0020, 1'b1, R_LINE, 16'hFFFF, 128'd0, 1'b0, 1'b1);
        issue("w_abort", 32'h8000_0020, 1'b1, 128'd0, 16'hFFFF, 128'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("abort_valid", 128'(resp_valid), 128'd0);
            check("abort_ready", 128'(req_ready), 128'd0);
        end
        rst = 1'b0;
        issue("r_abort", 32'h8000_0020, 1'b0, 128'd0, 16'h0000, R_LINE, 1'b0, 1'b1);
        drain("abort");
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
